// File: rtl/iic_slave_recv_if.sv
// Receive-side write port of iic_slave_recv: one strobed (word address, data)
// pair per accepted byte plus transfer status pulses.
interface iic_slave_recv_if;
    logic [7:0] word_addr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done_flag;
    logic       nack_flag;

    // slave: the IIC receiver producing the strobes
    modport slave (
        output word_addr,
        output rx_data,
        output rx_valid,
        output busy,
        output done_flag,
        output nack_flag
    );

    // master: register-file / RAM write logic consuming them
    modport master (
        input  word_addr,
        input  rx_data,
        input  rx_valid,
        input  busy,
        input  done_flag,
        input  nack_flag
    );
endinterface

// File: rtl/iic_slave_recv.sv
// IIC write-only slave: oversampled SCL/SDA, START/STOP detect, address match,
// word address + data reception. Optional macro IIC_AUTO_INC_EN enables multi-byte auto-increment.
module iic_slave_recv #(
    parameter logic [6:0] C_DEV_ADDR    = 7'h50,
    parameter int          C_SYNC_STAGES = 2
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_scl,
    inout  wire  IO_sda,
    iic_slave_recv_if.slave rx_if
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WORD,
        ST_WORD_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    logic [C_SYNC_STAGES-1:0] scl_sync_reg;
    logic [C_SYNC_STAGES-1:0] sda_sync_reg;
    logic                     scl_hist_reg;
    logic                     sda_hist_reg;
    logic                     sda_pin;
    logic                     scl_s;
    logic                     sda_s;
    logic                     scl_rise;
    logic                     scl_fall;
    logic                     start_det;
    logic                     stop_det;

    state_t     state_reg,     state_next;
    logic [2:0] bit_cnt_reg,   bit_cnt_next;
    logic       byte_full_reg, byte_full_next;
    logic [7:0] shift_reg,     shift_next;
    logic [7:0] addr_reg,      addr_next;
    logic [7:0] word_addr_reg, word_addr_next;
    logic [7:0] rx_data_reg,   rx_data_next;
    logic       rx_valid_reg,  rx_valid_next;
    logic       done_reg,      done_next;
    logic       nack_reg,      nack_next;
    logic       rx_seen_reg,   rx_seen_next;
    logic       data_got_reg,  data_got_next;
    logic       busy_reg;
    logic       sda_low_reg;
    logic       accept_ok;

    assign sda_pin = IO_sda;

    // Synchronizers reset to 1 so an idle bus produces no spurious edge at release.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[C_SYNC_STAGES-2:0], I_scl};
            sda_sync_reg <= {sda_sync_reg[C_SYNC_STAGES-2:0], sda_pin};
            scl_hist_reg <= scl_sync_reg[C_SYNC_STAGES-1];
            sda_hist_reg <= sda_sync_reg[C_SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_reg[C_SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[C_SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_hist_reg;
    assign scl_fall  = ~scl_s &  scl_hist_reg;
    assign start_det =  scl_s &  scl_hist_reg & ~sda_s &  sda_hist_reg;
    assign stop_det  =  scl_s &  scl_hist_reg &  sda_s & ~sda_hist_reg;

    // Without auto-increment only the first data byte of a transfer is taken.
`ifdef IIC_AUTO_INC_EN
    assign accept_ok = 1'b1;
`else
    assign accept_ok = ~data_got_reg;
`endif

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        byte_full_next = byte_full_reg;
        shift_next     = shift_reg;
        addr_next      = addr_reg;
        word_addr_next = word_addr_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        done_next      = 1'b0;
        nack_next      = 1'b0;
        rx_seen_next   = rx_seen_reg;
        data_got_next  = data_got_reg;

        if (stop_det) begin
            state_next     = ST_IDLE;
            done_next      = rx_seen_reg;
            rx_seen_next   = 1'b0;
            data_got_next  = 1'b0;
            bit_cnt_next   = 3'd0;
            byte_full_next = 1'b0;
        end else if (start_det) begin
            state_next     = ST_ADDR;
            rx_seen_next   = 1'b0;
            data_got_next  = 1'b0;
            bit_cnt_next   = 3'd0;
            byte_full_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_WORD, ST_DATA: begin
                    if (scl_rise && !byte_full_reg) begin
                        shift_next     = {shift_reg[6:0], sda_s};
                        bit_cnt_next   = bit_cnt_reg + 3'd1;
                        byte_full_next = (bit_cnt_reg == 3'd7);
                    end else if (scl_fall && byte_full_reg) begin
                        // Falling edge after the 8th bit opens the ACK slot.
                        bit_cnt_next   = 3'd0;
                        byte_full_next = 1'b0;
                        if (state_reg == ST_ADDR) begin
                            if (shift_reg == {C_DEV_ADDR, 1'b0}) begin
                                state_next = ST_ADDR_ACK;
                            end else begin
                                nack_next  = 1'b1;
                                state_next = ST_IGNORE;
                            end
                        end else if (state_reg == ST_WORD) begin
                            addr_next  = shift_reg;
                            state_next = ST_WORD_ACK;
                        end else if (accept_ok) begin
                            rx_data_next   = shift_reg;
                            word_addr_next = addr_reg;
                            rx_valid_next  = 1'b1;
                            rx_seen_next   = 1'b1;
                            data_got_next  = 1'b1;
                            state_next     = ST_DATA_ACK;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: if (scl_fall) state_next = ST_WORD;
                ST_WORD_ACK: if (scl_fall) state_next = ST_DATA;
                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        state_next = ST_DATA;
`ifdef IIC_AUTO_INC_EN
                        addr_next  = addr_reg + 8'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            byte_full_reg <= 1'b0;
            shift_reg     <= 8'd0;
            addr_reg      <= 8'd0;
            word_addr_reg <= 8'd0;
            rx_data_reg   <= 8'd0;
            rx_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
            nack_reg      <= 1'b0;
            rx_seen_reg   <= 1'b0;
            data_got_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            sda_low_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            byte_full_reg <= byte_full_next;
            shift_reg     <= shift_next;
            addr_reg      <= addr_next;
            word_addr_reg <= word_addr_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            done_reg      <= done_next;
            nack_reg      <= nack_next;
            rx_seen_reg   <= rx_seen_next;
            data_got_reg  <= data_got_next;
            busy_reg      <= (state_next != ST_IDLE);
            // Drive follows the ACK state one cycle later; START/STOP release at once.
            sda_low_reg   <= ~(start_det | stop_det) &
                             ((state_reg == ST_ADDR_ACK) ||
                              (state_reg == ST_WORD_ACK) ||
                              (state_reg == ST_DATA_ACK));
        end
    end

    assign IO_sda = sda_low_reg ? 1'b0 : 1'bz;

    assign rx_if.word_addr = word_addr_reg;
    assign rx_if.rx_data   = rx_data_reg;
    assign rx_if.rx_valid  = rx_valid_reg;
    assign rx_if.busy      = busy_reg;
    assign rx_if.done_flag = done_reg;
    assign rx_if.nack_flag = nack_reg;

endmodule

// File: tb/tb_iic_slave_recv.sv
// Bench for iic_slave_recv: bit-banged IIC master, scoreboard of expected
// (word address, data) strobes, one task per scenario.
module tb_iic_slave_recv;

    logic clk = 1'b0;
    logic rst;
    logic scl;
    logic sda_m_low;
    wire  sda;

    pullup (sda);
    assign sda = sda_m_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    iic_slave_recv_if rx_if ();

    iic_slave_recv #(
        .C_DEV_ADDR    (7'h50),
        .C_SYNC_STAGES (2)
    ) dut (
        .I_clk  (clk),
        .I_rst  (rst),
        .I_scl  (scl),
        .IO_sda (sda),
        .rx_if  (rx_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int valid_cnt    = 0;
    int done_cnt     = 0;
    int nack_cnt     = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_item;

    // Scoreboard: every strobe must match the oldest expected pair.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.rx_valid) begin
                valid_cnt++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rx_strobe_unexpected: got addr=%02h data=%02h, required no strobe",
                             rx_if.word_addr, rx_if.rx_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({rx_if.word_addr, rx_if.rx_data} !== exp_item) begin
                        tests_failed++;
                        $display("FAIL rx_strobe: got addr=%02h data=%02h, required addr=%02h data=%02h",
                                 rx_if.word_addr, rx_if.rx_data, exp_item[15:8], exp_item[7:0]);
                    end else begin
                        $display("[TB] strobe addr=%02h data=%02h ok", rx_if.word_addr, rx_if.rx_data);
                    end
                end
            end
            if (rx_if.done_flag) done_cnt++;
            if (rx_if.nack_flag) nack_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // All bus tasks start and end 6 cycles into an SCL low phase (or with the bus idle).
    task automatic send_start();
        if (scl) begin
            sda_m_low = 1'b1;
            wait_clk(12);
            scl = 1'b0;
            wait_clk(6);
        end else begin
            sda_m_low = 1'b0;
            wait_clk(6);
            scl = 1'b1;
            wait_clk(6);
            sda_m_low = 1'b1;
            wait_clk(6);
            scl = 1'b0;
            wait_clk(6);
        end
    endtask

    task automatic send_stop();
        sda_m_low = 1'b1;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(6);
        sda_m_low = 1'b0;
        wait_clk(12);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m_low = ~b[i];
            wait_clk(6);
            scl = 1'b1;
            wait_clk(12);
            scl = 1'b0;
            wait_clk(6);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked, output logic released);
        send_bits(b, 8);
        sda_m_low = 1'b0;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(6);
        acked = (sda === 1'b0);
        wait_clk(6);
        scl = 1'b0;
        wait_clk(6);
        released = (sda === 1'b1);
    endtask

    task automatic xfer_byte(input string name, input logic [7:0] b, input logic exp_ack);
        logic acked, released;
        send_byte(b, acked, released);
        tests_run++;
        if (acked !== exp_ack) begin
            tests_failed++;
            $display("FAIL %s_ack byte=%02h: got ack=%0b, required ack=%0b", name, b, acked, exp_ack);
        end else begin
            $display("[TB] %s byte=%02h ack=%0b ok", name, b, acked);
        end
        tests_run++;
        if (released !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_release byte=%02h: got sda=%0b, required 1", name, b, sda);
        end
    endtask

    task automatic check_counts(input string name, input int ev, input int ed, input int en);
        tests_run++;
        if (valid_cnt != ev || done_cnt != ed || nack_cnt != en || exp_q.size() != 0 ||
            rx_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_counts: got valid=%0d done=%0d nack=%0d pending=%0d busy=%0b, required valid=%0d done=%0d nack=%0d pending=0 busy=0",
                     name, valid_cnt, done_cnt, nack_cnt, exp_q.size(), rx_if.busy, ev, ed, en);
        end else begin
            $display("[TB] %s counts valid=%0d done=%0d nack=%0d ok", name, valid_cnt, done_cnt, nack_cnt);
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        done_cnt  = 0;
        nack_cnt  = 0;
    endtask

    task automatic check_outputs_zero(input string name);
        tests_run++;
        if (rx_if.word_addr !== 8'h00 || rx_if.rx_data !== 8'h00 || rx_if.rx_valid !== 1'b0 ||
            rx_if.busy !== 1'b0 || rx_if.done_flag !== 1'b0 || rx_if.nack_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_outputs: got addr=%02h data=%02h valid=%0b busy=%0b done=%0b nack=%0b, required all 0",
                     name, rx_if.word_addr, rx_if.rx_data, rx_if.rx_valid, rx_if.busy,
                     rx_if.done_flag, rx_if.nack_flag);
        end
        tests_run++;
        if (sda !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_sda: got %0b, required released (1)", name, sda);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        scl = 1'b1;
        sda_m_low = 1'b0;
        wait_clk(3);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        wait_clk(5);
        $display("[TB] reset done");
    endtask

    task automatic test_basic_write();
        clear_counts();
        send_start();
        tests_run++;
        if (rx_if.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy: got %0b, required 1", rx_if.busy);
        end
        xfer_byte("basic_dev", 8'hA0, 1'b1);
        xfer_byte("basic_word", 8'h12, 1'b1);
        exp_q.push_back({8'h12, 8'h5A});
        xfer_byte("basic_data", 8'h5A, 1'b1);
        send_stop();
        check_counts("basic", 1, 1, 0);
    endtask

    task automatic test_addr_mismatch();
        clear_counts();
        send_start();
        xfer_byte("mismatch_dev", 8'hA2, 1'b0);
        xfer_byte("mismatch_b1", 8'h12, 1'b0);
        xfer_byte("mismatch_b2", 8'h34, 1'b0);
        send_stop();
        check_counts("mismatch", 0, 0, 1);
    endtask

    task automatic test_read_nack();
        clear_counts();
        send_start();
        xfer_byte("read_dev", 8'hA1, 1'b0);
        xfer_byte("read_b1", 8'h00, 1'b0);
        tests_run++;
        if (rx_if.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_busy_ignore: got %0b, required 1", rx_if.busy);
        end
        send_stop();
        check_counts("read", 0, 0, 1);
    endtask

    task automatic test_auto_inc();
        clear_counts();
        send_start();
        xfer_byte("inc_dev", 8'hA0, 1'b1);
        xfer_byte("inc_word", 8'hFE, 1'b1);
        exp_q.push_back({8'hFE, 8'h11});
        xfer_byte("inc_d0", 8'h11, 1'b1);
`ifdef IIC_AUTO_INC_EN
        exp_q.push_back({8'hFF, 8'h22});
        xfer_byte("inc_d1", 8'h22, 1'b1);
        exp_q.push_back({8'h00, 8'h33});
        xfer_byte("inc_d2", 8'h33, 1'b1);
        send_stop();
        check_counts("inc", 3, 1, 0);
`else
        xfer_byte("inc_d1", 8'h22, 1'b0);
        xfer_byte("inc_d2", 8'h33, 1'b0);
        send_stop();
        check_counts("inc", 1, 1, 0);
`endif
    endtask

    task automatic test_repeated_start();
        clear_counts();
        send_start();
        xfer_byte("rs_dev0", 8'hA0, 1'b1);
        xfer_byte("rs_word0", 8'h40, 1'b1);
        send_bits(8'hA5, 4);
        send_start();
        xfer_byte("rs_dev1", 8'hA0, 1'b1);
        xfer_byte("rs_word1", 8'h41, 1'b1);
        exp_q.push_back({8'h41, 8'h77});
        xfer_byte("rs_data", 8'h77, 1'b1);
        send_stop();
        check_counts("rs", 1, 1, 0);
    endtask

    task automatic test_reset_mid_ack();
        clear_counts();
        send_start();
        send_bits(8'hA0, 8);
        sda_m_low = 1'b0;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(3);
        @(negedge clk);
        tests_run++;
        if (sda !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_ack_driven: got sda=%0b, required 0", sda);
        end
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        wait_clk(3);
        scl = 1'b0;
        wait_clk(6);
        rst = 1'b0;
        wait_clk(2);
        send_stop();
        send_start();
        xfer_byte("post_rst_dev", 8'hA0, 1'b1);
        xfer_byte("post_rst_word", 8'h03, 1'b1);
        exp_q.push_back({8'h03, 8'hC3});
        xfer_byte("post_rst_data", 8'hC3, 1'b1);
        send_stop();
        check_counts("post_rst", 1, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_addr_mismatch();
        test_read_nack();
        test_auto_inc();
        test_repeated_start();
        test_reset_mid_ack();
        wait_clk(4);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
